reduct_pipe: RTL

Pipelined, multi-mode bit-reduction unit for the ALU datapath. It reduces a WIDTH-bit operand to one bit using OR, AND, XOR (parity) or NOR (zero-detect). The work is split into two register stages: per-chunk partials, then a final combine. Both stages use a valid/ready elastic handshake, and a flush input lets the core squash in-flight results on a pipeline redirect.

---
 rtl/reduct_pipe.sv | 110 +++++++++++
 1 files changed

// File: rtl/reduct_pipe.sv
// reduct_pipe: two-stage elastic bit-reduction unit.
// Stage 1 reduces each CHUNK-bit slice of the operand to a partial bit.
// Stage 2 combines the partials into the final result, inverting for NOR.
// Both stages use valid/ready handshakes. A flush squashes whatever is in flight.
module reduct_pipe #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_bit,
   output logic [TAG_W-1:0] out_tag
);

   localparam int NC = WIDTH / CHUNK;

   typedef enum logic [1:0] {
      OP_OR  = 2'b00,
      OP_AND = 2'b01,
      OP_XOR = 2'b10,
      OP_NOR = 2'b11
   } op_e;

   logic             v1_q, v1_d;
   op_e              op1_q;
   logic [TAG_W-1:0] tag1_q;
   logic [NC-1:0]    p1_q, p1_d;

   logic             v2_q, v2_d;
   logic             bit2_q, bit2_d;
   logic [TAG_W-1:0] tag2_q;

   logic             inXfer;
   logic             adv2;
   logic             s1Load;

   // Per-chunk partials; NOR shares the OR partials and is inverted at the end.
   always_comb begin
      p1_d = '0;
      for (int i = 0; i < NC; i++) begin
         case (op_e'(in_op))
            OP_AND:  p1_d[i] = &in_a[i*CHUNK +: CHUNK];
            OP_XOR:  p1_d[i] = ^in_a[i*CHUNK +: CHUNK];
            default: p1_d[i] = |in_a[i*CHUNK +: CHUNK];
         endcase
      end
   end

   // Final combine of the stage-1 partials into the result bit.
   always_comb begin
      bit2_d = 1'b0;
      case (op1_q)
         OP_AND:  bit2_d = &p1_q;
         OP_XOR:  bit2_d = ^p1_q;
         OP_NOR:  bit2_d = ~(|p1_q);
         default: bit2_d = |p1_q;
      endcase
   end

   // Handshake and occupancy: S2 drains from S1 whenever it is empty or being
   // consumed, which also collapses bubbles while the consumer stalls.
   always_comb begin
      in_ready = ~rst & (~v1_q | ~v2_q | out_ready);
      inXfer   = in_valid & in_ready & ~flush & ~rst;
      adv2     = v1_q & (~v2_q | out_ready);
      s1Load   = inXfer & (~v1_q | adv2);
      v1_d     = inXfer | (v1_q & ~adv2);
      v2_d     = adv2 | (v2_q & ~out_ready);
   end

   // Valid bits and the stage-2 result registers; reset wins over flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q   <= 1'b0;
         v2_q   <= 1'b0;
         bit2_q <= 1'b0;
         tag2_q <= '0;
      end else begin
         v1_q <= flush ? 1'b0 : v1_d;
         v2_q <= flush ? 1'b0 : v2_d;
         if (adv2) begin
            bit2_q <= bit2_d;
            tag2_q <= tag1_q;
         end
      end
   end

   // Stage-1 payload needs no reset because v1 qualifies it.
   always_ff @(posedge clk) begin
      if (s1Load) begin
         op1_q  <= op_e'(in_op);
         tag1_q <= in_tag;
         p1_q   <= p1_d;
      end
   end

   assign out_valid = v2_q;
   assign out_bit   = bit2_q;
   assign out_tag   = tag2_q;

endmodule
